// File: rtl/det_pkg.sv
// Shared types and constants for the det_1011 job scheduler and its detector.
package det_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } sched_state_t;

  localparam int unsigned PATTERN_LEN = 4;

  // Width able to hold any count from 0 to w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/det_seq_sched_if.sv
// Requester-side bundle of the shared-detector scheduler.
interface det_seq_sched_if
  import det_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = cnt_width(W)
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [CNT_W-1:0]  match_cnt;
  logic              busy;

  modport master (
    output req, req_data,
    input  grant, done, match_cnt, busy
  );

  modport slave (
    input  req, req_data,
    output grant, done, match_cnt, busy
  );

endinterface

// File: rtl/det_1011.sv
// Serial 1011 detector, non-overlapping, registered one-cycle match pulse.
module det_1011
  import det_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  localparam int unsigned LEN_W = $clog2(PATTERN_LEN);

  // Number of pattern bits matched so far (0..PATTERN_LEN-1).
  logic [LEN_W-1:0] st;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st   <= '0;
      dout <= 1'b0;
    end else begin
      dout <= (st == LEN_W'(PATTERN_LEN - 1)) && din;
      case (st)
        LEN_W'(0): st <= din ? LEN_W'(1) : LEN_W'(0);
        LEN_W'(1): st <= din ? LEN_W'(1) : LEN_W'(2);
        LEN_W'(2): st <= din ? LEN_W'(3) : LEN_W'(0);
        default:   st <= din ? LEN_W'(0) : LEN_W'(2);
      endcase
    end
  end

endmodule

// File: rtl/det_seq_sched_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  localparam int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_c,
  output logic             valid_c
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] hi;
  logic [NREQ-1:0] sel;

  // Keep bits >= ptr; fall back to the full vector to wrap around.
  assign mask    = ~((NREQ'(1) << ptr) - NREQ'(1));
  assign hi      = req & mask;
  assign sel     = (|hi) ? hi : req;
  assign gnt_c   = sel & (~sel + NREQ'(1));
  assign valid_c = |req;

endmodule

// File: rtl/det_seq_sched.sv
// Round-robin scheduler sharing one serial 1011 detector among NREQ requesters.
module det_seq_sched
  import det_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = cnt_width(W)
) (
  input  logic                  clk,
  input  logic                  rst,
  det_seq_sched_if.slave        bus,
  output logic                  det_in,
  output logic                  det_rstn,
  input  logic                  det_out
);

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned IDX_W = $clog2(W);

  sched_state_t     state;
  logic [PTR_W-1:0] ptr;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  done_q;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [W-1:0]     shift_reg;
  logic [IDX_W-1:0] idx;

  logic [NREQ-1:0]  arb_gnt_c;
  logic             arb_valid_c;
  logic [W-1:0]     sel_word_c;
  logic [PTR_W-1:0] owner_c;
  logic [PTR_W-1:0] next_ptr_c;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr),
    .gnt_c   (arb_gnt_c),
    .valid_c (arb_valid_c)
  );

  // Word belonging to the arbitration winner.
  always_comb begin
    sel_word_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (arb_gnt_c[i]) sel_word_c = bus.req_data[i*W +: W];
    end
  end

  // Index of the current owner and the pointer slot just past it.
  always_comb begin
    owner_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_q[i]) owner_c = PTR_W'(i);
    end
    next_ptr_c = (owner_c == PTR_W'(NREQ - 1)) ? '0 : owner_c + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      match_q   <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      shift_reg <= '0;
      idx       <= '0;
      det_in    <= 1'b0;
      det_rstn  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (arb_valid_c) begin
            shift_reg <= sel_word_c;
            grant_q   <= arb_gnt_c;
            cnt       <= '0;
            busy_q    <= 1'b1;
            det_in    <= 1'b0;
            det_rstn  <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          det_rstn  <= 1'b1;
          det_in    <= shift_reg[W-1];
          shift_reg <= {shift_reg[W-2:0], 1'b0};
          idx       <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          // det_out here reflects the bit presented one cycle earlier.
          cnt <= cnt + CNT_W'(det_out);
          if (idx == IDX_W'(W - 1)) begin
            det_in <= 1'b0;
            state  <= DRAIN;
          end else begin
            det_in    <= shift_reg[W-1];
            shift_reg <= {shift_reg[W-2:0], 1'b0};
            idx       <= idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          match_q  <= cnt + CNT_W'(det_out);
          done_q   <= grant_q;
          det_rstn <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr     <= next_ptr_c;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.match_cnt = match_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_det_seq_sched.sv
// Self-checking bench for det_seq_sched driving a real det_1011.
module tb_det_seq_sched;
  import det_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 5;

  logic clk;
  logic rst;
  logic det_in;
  logic det_rstn;
  logic det_out;

  int n_checks;
  int n_fail;
  int m_ptr;

  det_seq_sched_if #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) bus ();

  det_seq_sched #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .det_in   (det_in),
    .det_rstn (det_rstn),
    .det_out  (det_out)
  );

  det_1011 u_det (
    .clk  (clk),
    .rstn (det_rstn),
    .din  (det_in),
    .dout (det_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          idx;
    logic [15:0] word;
    int          exp_cnt;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Greedy leftmost non-overlapping count of 1011 in the MSB-first bit string.
  function automatic int ref_count(input logic [15:0] w);
    int c;
    int i;
    logic [3:0] win;
    logic [3:0] pat;
    c = 0;
    i = 0;
    pat = 4'b1011;
    while (i <= int'(W - PATTERN_LEN)) begin
      win = w[15-i -: 4];
      if (win == pat) begin
        c++;
        i += PATTERN_LEN;
      end else begin
        i++;
      end
    end
    return c;
  endfunction

  // First pending requester at or after ptr, wrapping.
  function automatic int pick(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < int'(NREQ); k++) begin
      if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  // Called in the grant cycle with req[owner] already high; returns in the next IDLE cycle.
  task automatic do_job(input string name, input int owner, input logic [15:0] word,
                        input int exp_cnt, input bit scramble, input bit keep,
                        output logic [15:0] new_word);
    int n;
    new_word = word;
    tick();
    check({name, " grant"}, 32'(bus.grant), 32'(1) << owner);
    check({name, " busy"}, 32'(bus.busy), 32'd1);
    check({name, " det_rstn clear"}, 32'(det_rstn), 32'd0);
    tick();
    check({name, " det_rstn shift"}, 32'(det_rstn), 32'd1);
    check({name, " first bit"}, 32'(det_in), 32'(word[15]));
    n = 2;
    if (scramble) begin
      new_word = 16'($urandom);
      bus.req_data[owner*W +: W] = new_word;
    end
    while (bus.done == '0 && n < 40) begin
      tick();
      n++;
    end
    check({name, " done latency"}, 32'(n), 32'd19);
    check({name, " done"}, 32'(bus.done), 32'(1) << owner);
    check({name, " match_cnt"}, 32'(bus.match_cnt), 32'(exp_cnt));
    if (!keep) bus.req[owner] = 1'b0;
    m_ptr = (owner + 1) % NREQ;
    tick();
    check({name, " idle done"}, 32'(bus.done), 32'd0);
    check({name, " idle grant"}, 32'(bus.grant), 32'd0);
    check({name, " idle busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [15:0] nw;
    logic [15:0] words[4];
    logic [3:0]  pending;
    logic [3:0]  kept;
    int          owner;
    int          dones;
    bit          keep;
    bit          scr;

    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    rst      = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;

    vecs[0] = '{0, 16'hB000, 1};
    vecs[1] = '{2, 16'hBBBB, 4};
    vecs[2] = '{1, 16'h5A5A, 2};
    vecs[3] = '{3, 16'h0000, 0};
    vecs[4] = '{0, 16'hFFFF, 0};
    vecs[5] = '{1, 16'hB0B0, 2};
    vecs[6] = '{2, 16'h000B, 1};

    // Reset state
    tick();
    tick();
    check("rst grant", 32'(bus.grant), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst match_cnt", 32'(bus.match_cnt), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst det_in", 32'(det_in), 32'd0);
    check("rst det_rstn", 32'(det_rstn), 32'd0);
    rst = 1'b0;

    // Table: single requester jobs
    for (int v = 0; v < 7; v++) begin
      bus.req_data[vecs[v].idx*W +: W] = vecs[v].word;
      bus.req[vecs[v].idx] = 1'b1;
      do_job($sformatf("vec%0d", v), vecs[v].idx, vecs[v].word, vecs[v].exp_cnt, 1'b0, 1'b0, nw);
    end

    // Four simultaneous requests from pointer 0
    do_reset();
    bus.req_data = {16'h0000, 16'h5A5A, 16'hBBBB, 16'hB000};
    bus.req = 4'b1111;
    do_job("all0", 0, 16'hB000, 1, 1'b0, 1'b0, nw);
    do_job("all1", 1, 16'hBBBB, 4, 1'b0, 1'b0, nw);
    do_job("all2", 2, 16'h5A5A, 2, 1'b0, 1'b0, nw);
    do_job("all3", 3, 16'h0000, 0, 1'b0, 1'b0, nw);

    // Requester 1 holds req through its done while 3 waits
    bus.req_data[1*W +: W] = 16'h5A5A;
    bus.req_data[3*W +: W] = 16'hB000;
    bus.req = 4'b1010;
    do_job("hold1a", 1, 16'h5A5A, 2, 1'b0, 1'b1, nw);
    bus.req_data[1*W +: W] = 16'hBBBB;
    do_job("hold3", 3, 16'hB000, 1, 1'b0, 1'b0, nw);
    do_job("hold1b", 1, 16'hBBBB, 4, 1'b0, 1'b0, nw);

    // Reset in the middle of a job
    bus.req_data[2*W +: W] = 16'hBBBB;
    bus.req[2] = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst grant", 32'(bus.grant), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst det_rstn", 32'(det_rstn), 32'd0);
    check("midrst match_cnt", 32'(bus.match_cnt), 32'd0);
    bus.req = '0;
    tick();
    rst = 1'b0;
    m_ptr = 0;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.done != '0) dones++;
    end
    check("midrst no done", 32'(dones), 32'd0);
    bus.req_data[0*W +: W] = 16'h5A5A;
    bus.req[0] = 1'b1;
    do_job("after_rst", 0, 16'h5A5A, 2, 1'b0, 1'b0, nw);

    // Randomized rounds against the reference model
    for (int r = 0; r < 12; r++) begin
      pending = 4'($urandom_range(1, 15));
      kept = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        words[i] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) words[i] = 16'hB000 | 16'($urandom_range(0, 4095));
        bus.req_data[i*W +: W] = words[i];
      end
      bus.req = pending;
      while (pending != '0) begin
        owner = pick(pending, m_ptr);
        keep  = !kept[owner] && ($urandom_range(0, 3) == 0);
        scr   = 1'($urandom_range(0, 1));
        do_job($sformatf("rnd%0d_r%0d", r, owner), owner, words[owner],
               ref_count(words[owner]), scr, keep, nw);
        if (keep) begin
          kept[owner] = 1'b1;
          words[owner] = nw;
        end else begin
          pending[owner] = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
